// File: rtl/rr_arb_stage.sv
// rr_arb_stage: registered round-robin arbiter.
// Merges NREQ request/data lanes into a single valid/ready beat stream and
// sustains one beat per cycle. A one-hot priority pointer (rot) is masked
// into a thermometer so that priority is circular. The pointer steps to the
// lane just above each winner.
//
// Optional feature, enabled with macro RR_ARB_STAGE_LOCK_EN:
//   Adds the lock input. A lane accepted with its lock bit set becomes the
//   owner. Only the owner is eligible until it sends a beat with lock low.
//   The pointer does not advance on locked accepts.
//
// Ports:
//   clk       in   clock, rising-edge
//   rst       in   synchronous active-high reset
//   req       in   [NREQ]    per-lane request
//   din       in   [NREQ*DW] lane i data at din[i*DW +: DW]
//   lock      in   [NREQ]    per-lane lock qualifier (RR_ARB_STAGE_LOCK_EN only)
//   req_rdy   out  [NREQ]    one-hot accept (combinational)
//   out_vld   out            output register holds a beat
//   out_rdy   in             downstream accepts
//   out_data  out  [DW]      captured beat
//   out_gnt   out  [NREQ]    one-hot lane of captured beat
//   out_idx   out  [NW]      binary lane of captured beat
//   rot       out  [NREQ]    one-hot priority pointer (registered)
module rr_arb_stage #(
  parameter int unsigned NREQ = 8,
  parameter int unsigned DW   = 16,
  parameter int unsigned NW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*DW-1:0] din,
`ifdef RR_ARB_STAGE_LOCK_EN
  input  logic [NREQ-1:0]   lock,
`endif
  output logic [NREQ-1:0]   req_rdy,
  output logic              out_vld,
  input  logic              out_rdy,
  output logic [DW-1:0]     out_data,
  output logic [NREQ-1:0]   out_gnt,
  output logic [NW-1:0]     out_idx,
  output logic [NREQ-1:0]   rot
);

  logic              out_vld_q,  out_vld_d;
  logic [DW-1:0]     out_data_q, out_data_d;
  logic [NREQ-1:0]   out_gnt_q,  out_gnt_d;
  logic [NW-1:0]     out_idx_q,  out_idx_d;
  logic [NREQ-1:0]   rot_q,      rot_d;

  logic              ld;
  logic [NREQ-1:0]   elig;
  logic [NREQ-1:0]   masked;
  logic [NREQ-1:0]   pick;
  logic [NREQ-1:0]   win;
  logic [NREQ-1:0]   win_rotl;
  logic [DW-1:0]     win_data;
  logic [NW-1:0]     win_idx;
  logic              arb;

`ifdef RR_ARB_STAGE_LOCK_EN
  logic              locked_q, locked_d;
  logic [NREQ-1:0]   owner_q,  owner_d;   // one-hot owner lane
`endif

  assign ld = ~out_vld_q | out_rdy;

`ifdef RR_ARB_STAGE_LOCK_EN
  assign elig = locked_q ? (req & owner_q) : req;
`else
  assign elig = req;
`endif

  // For a one-hot rot, ~(rot - 1) sets rot's bit and every bit above it.
  assign masked   = elig & ~(rot_q - NREQ'(1));
  assign pick     = (|masked) ? masked : elig;
  // Two's-complement trick isolates the lowest set bit.
  assign win      = pick & (~pick + NREQ'(1));
  assign win_rotl = {win[NREQ-2:0], win[NREQ-1]};
  assign arb      = ld & (|elig) & ~rst;
  assign req_rdy  = arb ? win : '0;

  always_comb begin
    win_data = '0;
    win_idx  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (win[i]) begin
        win_data = din[i*DW +: DW];
        win_idx  = NW'(i);
      end
    end
  end

  always_comb begin
    out_vld_d  = out_vld_q;
    out_data_d = out_data_q;
    out_gnt_d  = out_gnt_q;
    out_idx_d  = out_idx_q;
    rot_d      = rot_q;
`ifdef RR_ARB_STAGE_LOCK_EN
    locked_d   = locked_q;
    owner_d    = owner_q;
`endif
    if (ld) begin
      out_vld_d = |elig;
      if (|elig) begin
        out_data_d = win_data;
        out_gnt_d  = win;
        out_idx_d  = win_idx;
        rot_d      = win_rotl;
`ifdef RR_ARB_STAGE_LOCK_EN
        if (|(win & lock)) begin
          locked_d = 1'b1;
          owner_d  = win;
          rot_d    = rot_q;
        end else begin
          locked_d = 1'b0;
        end
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
      out_gnt_q  <= '0;
      out_idx_q  <= '0;
      rot_q      <= NREQ'(1);
    end else begin
      out_vld_q  <= out_vld_d;
      out_data_q <= out_data_d;
      out_gnt_q  <= out_gnt_d;
      out_idx_q  <= out_idx_d;
      rot_q      <= rot_d;
    end
  end

`ifdef RR_ARB_STAGE_LOCK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      locked_q <= 1'b0;
      owner_q  <= '0;
    end else begin
      locked_q <= locked_d;
      owner_q  <= owner_d;
    end
  end
`endif

  assign out_vld  = out_vld_q;
  assign out_data = out_data_q;
  assign out_gnt  = out_gnt_q;
  assign out_idx  = out_idx_q;
  assign rot      = rot_q;

endmodule
